cpu_cu: RTL and testbench



---
 rtl/cpu_cu_if.sv | 34 +++
 rtl/cpu_cu.sv | 165 ++++++++++++++++
 tb/tb_cpu_cu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_cu_if.sv
// Control/status bundle between the CPU control unit and the execution unit / memory.
// The master side is the control unit; the slave side is the EU and memory.
interface cpu_cu_if;
    logic [15:0] ir;
    logic        c;
    logic        n;
    logic        z;
    logic        mem_rdy;
    logic        eu_reset;
    logic        w_en;
    logic        s_sel;
    logic        pc_ld;
    logic        pc_inc;
    logic        ir_ld;
    logic        adr_sel;
    logic        mem_re;
    logic        mem_we;
    logic        instr_done;
    logic        halted;
    logic        fault;
    logic [3:0]  state;

    modport master (
        input  ir, c, n, z, mem_rdy,
        output eu_reset, w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel,
               mem_re, mem_we, instr_done, halted, fault, state
    );

    modport slave (
        output ir, c, n, z, mem_rdy,
        input  eu_reset, w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel,
               mem_re, mem_we, instr_done, halted, fault, state
    );
endinterface

// File: rtl/cpu_cu.sv
// Multi-cycle CPU control unit: fetch -> decode -> execute sequencing of the EU,
// memory handshake with a bounded wait, and a sticky fault stop.
module cpu_cu #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic      clk,
    input  logic      reset,
    cpu_cu_if.master  bus
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ALU    = 4'd3,
        S_LOAD   = 4'd4,
        S_STORE  = 4'd5,
        S_JUMP   = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(MEM_TIMEOUT);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] wait_cnt;
    logic            c_q;
    logic            n_q;
    logic            z_q;
    logic            fault_q;
    logic            mem_state;
    logic            timeout;
    logic            illegal;
    logic            cond_flag;
    logic            cond_true;

    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);
        timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_rdy && (wait_cnt == TO_VAL);
        illegal   = (state_q == S_DECODE) &&
                    ((bus.ir[11:9] == 3'b101) || (bus.ir[11:9] == 3'b110));
    end

    // Branches test the flag copy taken at the last ALU edge, never the live flags.
    always_comb begin
        case (bus.ir[1:0])
            2'b00:   cond_flag = z_q;
            2'b01:   cond_flag = n_q;
            2'b10:   cond_flag = c_q;
            default: cond_flag = 1'b1;
        endcase
        cond_true = cond_flag ^ bus.ir[2];
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (mem_state && !bus.mem_rdy && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
            if (state_q == S_ALU) begin
                c_q <= bus.c;
                n_q <= bus.n;
                z_q <= bus.z;
            end
            if (illegal || timeout)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_rdy)  state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
            end
            S_DECODE: begin
                case (bus.ir[11:9])
                    3'b000:  state_d = S_ALU;
                    3'b001:  state_d = S_LOAD;
                    3'b010:  state_d = S_STORE;
                    3'b011:  state_d = S_JUMP;
                    3'b100:  state_d = S_BRANCH;
                    default: state_d = S_HALT;
                endcase
            end
            S_LOAD, S_STORE: begin
                if (bus.mem_rdy)  state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
            end
            S_ALU, S_JUMP, S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.eu_reset   = 1'b0;
        bus.w_en       = 1'b0;
        bus.s_sel      = 1'b0;
        bus.pc_ld      = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.ir_ld      = 1'b0;
        bus.adr_sel    = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            S_RST: bus.eu_reset = 1'b1;
            S_FETCH: if (!timeout) begin
                bus.mem_re = 1'b1;
                bus.ir_ld  = bus.mem_rdy;
                bus.pc_inc = bus.mem_rdy;
            end
            S_ALU: begin
                bus.w_en       = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_LOAD: if (!timeout) begin
                bus.adr_sel    = 1'b1;
                bus.mem_re     = 1'b1;
                bus.w_en       = bus.mem_rdy;
                bus.s_sel      = bus.mem_rdy;
                bus.instr_done = bus.mem_rdy;
            end
            S_STORE: if (!timeout) begin
                bus.adr_sel    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.instr_done = bus.mem_rdy;
            end
            S_JUMP: begin
                bus.pc_ld      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.pc_ld      = cond_true;
                bus.instr_done = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.fault = fault_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu: each cycle compares {state, strobe vector} against
// hand-computed constants built from the strobe bit masks below.
module tb_cpu_cu;

    localparam logic [11:0] EU_RESET = 12'h800;
    localparam logic [11:0] W_EN     = 12'h400;
    localparam logic [11:0] S_SEL    = 12'h200;
    localparam logic [11:0] PC_LD    = 12'h100;
    localparam logic [11:0] PC_INC   = 12'h080;
    localparam logic [11:0] IR_LD    = 12'h040;
    localparam logic [11:0] ADR_SEL  = 12'h020;
    localparam logic [11:0] MEM_RE   = 12'h010;
    localparam logic [11:0] MEM_WE   = 12'h008;
    localparam logic [11:0] DONE     = 12'h004;
    localparam logic [11:0] HALTED   = 12'h002;
    localparam logic [11:0] FAULT    = 12'h001;
    localparam logic [11:0] NONE     = 12'h000;
    localparam logic [11:0] FETCH_OK = MEM_RE | IR_LD | PC_INC;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cpu_cu_if bus ();

    cpu_cu #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state/strobes %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] observed();
        return {bus.state, bus.eu_reset, bus.w_en, bus.s_sel, bus.pc_ld, bus.pc_inc,
                bus.ir_ld, bus.adr_sel, bus.mem_re, bus.mem_we, bus.instr_done,
                bus.halted, bus.fault};
    endfunction

    // Check outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [11:0] strobes);
        @(negedge clk);
        check(tag, observed(), {st, strobes});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.ir      = 16'h0000;
        bus.c       = 1'b0;
        bus.n       = 1'b0;
        bus.z       = 1'b0;
        bus.mem_rdy = 1'b1;
        do_reset(2);
        cyc("rst_state", 4'd0, EU_RESET);

        // ALU op with z=1, then a branch-on-Z must be taken.
        bus.ir = 16'hB040;
        bus.z  = 1'b1;
        cyc("alu_fetch",  4'd1, FETCH_OK);
        cyc("alu_decode", 4'd2, NONE);
        cyc("alu_exec",   4'd3, W_EN | DONE);
        bus.ir = 16'h0800;
        cyc("br_z_fetch",  4'd1, FETCH_OK);
        cyc("br_z_decode", 4'd2, NONE);
        cyc("br_z_taken",  4'd7, PC_LD | DONE);

        // ALU op with z=0; live z goes back to 1 but the copy must win.
        bus.ir = 16'hB040;
        bus.z  = 1'b0;
        cyc("alu2_fetch", 4'd1, FETCH_OK);
        cyc("alu2_decode", 4'd2, NONE);
        cyc("alu2_exec",  4'd3, W_EN | DONE);
        bus.z  = 1'b1;
        bus.ir = 16'h0800;
        cyc("br_nz_fetch",  4'd1, FETCH_OK);
        cyc("br_nz_decode", 4'd2, NONE);
        cyc("br_z_not_taken", 4'd7, DONE);
        bus.ir = 16'h0804;
        cyc("br_inv_fetch",  4'd1, FETCH_OK);
        cyc("br_inv_decode", 4'd2, NONE);
        cyc("br_inv_taken",  4'd7, PC_LD | DONE);

        bus.ir = 16'h0600;
        cyc("jmp_fetch",  4'd1, FETCH_OK);
        cyc("jmp_decode", 4'd2, NONE);
        cyc("jmp_exec",   4'd6, PC_LD | DONE);

        bus.ir = 16'h0400;
        cyc("st_fetch",  4'd1, FETCH_OK);
        cyc("st_decode", 4'd2, NONE);
        cyc("st_exec",   4'd5, ADR_SEL | MEM_WE | DONE);

        // LOAD with three wait cycles.
        bus.ir = 16'h0200;
        cyc("ld_fetch", 4'd1, FETCH_OK);
        bus.mem_rdy = 1'b0;
        cyc("ld_decode", 4'd2, NONE);
        for (int i = 0; i < 3; i++) cyc($sformatf("ld_wait%0d", i), 4'd4, ADR_SEL | MEM_RE);
        bus.mem_rdy = 1'b1;
        cyc("ld_done", 4'd4, ADR_SEL | MEM_RE | W_EN | S_SEL | DONE);

        // Legal HALT class: halted, no fault.
        bus.ir = 16'h0E00;
        cyc("halt_fetch",  4'd1, FETCH_OK);
        cyc("halt_decode", 4'd2, NONE);
        cyc("halt_hold0",  4'd8, HALTED);
        cyc("halt_hold1",  4'd8, HALTED);

        // mem_rdy arriving exactly at the timeout count still completes the fetch.
        do_reset(1);
        cyc("rst2", 4'd0, EU_RESET);
        bus.mem_rdy = 1'b0;
        bus.ir      = 16'h0A00;
        for (int i = 0; i < 15; i++) cyc($sformatf("edge_wait%0d", i), 4'd1, MEM_RE);
        bus.mem_rdy = 1'b1;
        cyc("edge_rdy_wins", 4'd1, FETCH_OK);
        cyc("ill_decode",    4'd2, NONE);
        cyc("ill_halt0",     4'd8, HALTED | FAULT);
        cyc("ill_halt1",     4'd8, HALTED | FAULT);

        // Reset clears the fault and restarts at FETCH.
        do_reset(1);
        cyc("rst3",       4'd0, EU_RESET);
        cyc("rst3_fetch", 4'd1, FETCH_OK);

        // Timeout: fetch never completes.
        bus.ir = 16'hB040;
        cyc("to_decode", 4'd2, NONE);
        cyc("to_alu",    4'd3, W_EN | DONE);
        bus.mem_rdy = 1'b0;
        for (int i = 0; i < 15; i++) cyc($sformatf("to_wait%0d", i), 4'd1, MEM_RE);
        cyc("to_expire", 4'd1, NONE);
        cyc("to_halt0",  4'd8, HALTED | FAULT);
        bus.mem_rdy = 1'b1;
        cyc("to_halt1",  4'd8, HALTED | FAULT);

        do_reset(2);
        cyc("rst4",       4'd0, EU_RESET);
        cyc("rst4_fetch", 4'd1, FETCH_OK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
